// File: rtl/alu_result_buffer_if.sv
// Bundle between the ALU result stage, the result buffer and its consumer.
// The slave modport is the buffer; the master modport is the ALU/consumer side.
interface alu_result_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_result;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_status;

  modport slave (
    input  in_valid, in_result, out_ready, clr_status,
    output out_valid, out_data, level, overflow, drop_count
  );

  modport master (
    output in_valid, in_result, out_ready, clr_status,
    input  out_valid, out_data, level, overflow, drop_count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO behind the ALU result stage; drops words when full and not
// popping, recording them in a sticky overflow flag and a saturating counter.
module alu_result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_count;

  logic w_full;
  logic w_out_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake: a word moves when out_valid & out_ready are both high at a
  // rising edge; out_valid/out_data hold steady while out_ready is low.
  // The input side has no ready: in_valid words are taken or dropped.
  assign w_full      = (r_level == FULL_LVL);
  assign w_out_valid = (r_level != '0);
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_push      = bus.in_valid & (~w_full | w_pop);
  assign w_drop      = bus.in_valid & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.clr_status) begin
        r_drop_count <= CNT_W'(1);
      end else if (!(&r_drop_count)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end else if (bus.clr_status) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_mem[r_rd_ptr] : DATA_W'(0);
  assign bus.level      = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: reset, passthrough, fill/drop,
// full push+pop, counter saturation/clear and mid-operation reset.
module tb_alu_result_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [DATA_W-1:0] exp_q [$];

  alu_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    bus.in_valid  = 1'b1;
    bus.in_result = w;
    step();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_result  = 16'h1234;
    bus.out_ready  = 1'b0;
    bus.clr_status = 1'b0;
    #2 rst_n = 1'b0;

    // Reset held with in_valid active
    repeat (3) step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_level", bus.level, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_drop_count", bus.drop_count, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single passthrough
    bus.out_ready = 1'b1;
    push_word(16'h0005);
    check("pass_valid", bus.out_valid, 1);
    check("pass_data", bus.out_data, 16'h0005);
    check("pass_level1", bus.level, 1);
    step();
    check("pass_level0", bus.level, 0);
    check("pass_valid0", bus.out_valid, 0);
    check("pass_data0", bus.out_data, 0);
    check("pass_no_drop", bus.drop_count, 0);

    // Fill and drop
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_word(DATA_W'(i));
      if (i == 4) begin
        check("fill_level4", bus.level, 4);
        check("fill_no_ovf", bus.overflow, 0);
      end
    end
    check("drop_level", bus.level, 4);
    check("drop_overflow", bus.overflow, 1);
    check("drop_count1", bus.drop_count, 1);
    check("drop_head_stable", bus.out_data, 16'h0001);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(i));
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("drain1_valid", bus.out_valid, 1);
      check("drain1_data", bus.out_data, exp_q.pop_front());
      step();
    end
    check("drain1_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Clear alone
    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    check("clr_overflow", bus.overflow, 0);
    check("clr_count", bus.drop_count, 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
    check("full_level", bus.level, 4);
    bus.out_ready = 1'b1;
    check("full_head", bus.out_data, 16'h0001);
    push_word(16'hDEAD);
    check("pp_level", bus.level, 4);
    check("pp_drop_count", bus.drop_count, 0);
    check("pp_overflow", bus.overflow, 0);
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'hDEAD};
    while (exp_q.size() > 0) begin
      check("drain2_data", bus.out_data, exp_q.pop_front());
      step();
    end
    check("drain2_empty", bus.out_valid, 0);
    check("drain2_level", bus.level, 0);
    bus.out_ready = 1'b0;

    // Saturation
    for (int i = 0; i < 4; i++) push_word(DATA_W'(16'h0010 + i));
    bus.in_valid  = 1'b1;
    bus.in_result = 16'hBEEF;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) check("sat_count254", bus.drop_count, 254);
      if (i == 255) check("sat_count255", bus.drop_count, 255);
    end
    bus.in_valid = 1'b0;
    check("sat_hold", bus.drop_count, 255);
    check("sat_overflow", bus.overflow, 1);
    check("sat_head", bus.out_data, 16'h0010);

    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    check("clr2_overflow", bus.overflow, 0);
    check("clr2_count", bus.drop_count, 0);
    check("clr2_level", bus.level, 4);

    // Clear and drop in the same cycle
    bus.clr_status = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_result  = 16'h7777;
    step();
    bus.clr_status = 1'b0;
    bus.in_valid   = 1'b0;
    check("clrdrop_overflow", bus.overflow, 1);
    check("clrdrop_count", bus.drop_count, 1);
    check("clrdrop_level", bus.level, 4);

    // Reset mid-operation
    bus.out_ready = 1'b1;
    repeat (4) step();
    bus.out_ready = 1'b0;
    check("pre_rst_empty", bus.level, 0);
    push_word(16'h0021);
    push_word(16'h0022);
    push_word(16'h0023);
    check("mid_level3", bus.level, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_data", bus.out_data, 0);
    check("async_level", bus.level, 0);
    check("async_overflow", bus.overflow, 0);
    check("async_count", bus.drop_count, 0);
    step();
    rst_n = 1'b1;
    push_word(16'h00AA);
    check("post_rst_level", bus.level, 1);
    check("post_rst_data", bus.out_data, 16'h00AA);
    bus.out_ready = 1'b1;
    step();
    repeat (3) step();
    check("post_rst_empty", bus.out_valid, 0);
    check("post_rst_level0", bus.level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
